// File: rtl/fsbm_pkg.sv
// fsbm_pkg: shared definitions for the full-search block-matching scheduler.
//   state_e        - search FSM state encoding
//   PHASE_LEN_DEF  - default cycles per candidate phase
//   INIT_CYC_DEF   - default cycles the memory-initialisation enable is held
//   POS_W          - width of candidate / motion-vector coordinates
package fsbm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int PHASE_LEN_DEF = 24;
    localparam int INIT_CYC_DEF  = 73;
    localparam int POS_W         = 5;

endpackage

// File: rtl/sad_min_track.sv
// sad_min_track: running minimum of SAD results with the candidate that produced it.
//   clk, rst_n      - clock, asynchronous active-low reset
//   load            - an accepted SAD result is present this cycle
//   first           - this is the first result of the search (load unconditionally)
//   sad, x, y       - SAD value and the candidate coordinates it belongs to
//   mv_x, mv_y      - best candidate so far
//   min_sad         - SAD of the best candidate
// Ties keep the earlier candidate (strict less-than compare).
module sad_min_track
    import fsbm_pkg::*;
#(
    parameter int SAD_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             first,
    input  logic [SAD_W-1:0] sad,
    input  logic [POS_W-1:0] x,
    input  logic [POS_W-1:0] y,
    output logic [POS_W-1:0] mv_x,
    output logic [POS_W-1:0] mv_y,
    output logic [SAD_W-1:0] min_sad
);

    logic [POS_W-1:0] mv_x_q, mv_x_d;
    logic [POS_W-1:0] mv_y_q, mv_y_d;
    logic [SAD_W-1:0] min_sad_q, min_sad_d;

    always_comb begin
        mv_x_d    = mv_x_q;
        mv_y_d    = mv_y_q;
        min_sad_d = min_sad_q;
        if (load && (first || (sad < min_sad_q))) begin
            mv_x_d    = x;
            mv_y_d    = y;
            min_sad_d = sad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv_x_q    <= '0;
            mv_y_q    <= '0;
            min_sad_q <= '0;
        end else begin
            mv_x_q    <= mv_x_d;
            mv_y_q    <= mv_y_d;
            min_sad_q <= min_sad_d;
        end
    end

    assign mv_x    = mv_x_q;
    assign mv_y    = mv_y_q;
    assign min_sad = min_sad_q;

endmodule

// File: rtl/search_sched.sv
// search_sched: full-search motion-estimation scheduler.
// Sequences memory init, issues N_POS x N_POS candidates in raster order
// (one per PHASE_LEN-cycle phase), collects SAD results in issue order and
// reports the best motion vector.
//   clk, rst_n            - clock, asynchronous active-low reset
//   start                 - begin a search (sampled in IDLE only)
//   abort                 - cancel the search in progress (no done pulse)
//   sad_valid, sad        - SAD result strobe/value for the oldest outstanding candidate
//   en_init               - memory-initialisation enable (INIT_CYC cycles)
//   phase_start           - one-cycle pulse opening a candidate phase
//   cand_x, cand_y        - candidate issued in the current phase
//   busy, done            - not-IDLE flag, one-cycle completion pulse
//   mv_x, mv_y, min_sad   - best candidate and its SAD
// Build option: SEARCH_SCHED_EARLY_TERM_EN - an accepted sad of zero ends
// the search immediately.
module search_sched
    import fsbm_pkg::*;
#(
    parameter int SAD_W     = 16,
    parameter int N_POS     = 16,
    parameter int PHASE_LEN = PHASE_LEN_DEF,
    parameter int INIT_CYC  = INIT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             sad_valid,
    input  logic [SAD_W-1:0] sad,
    output logic             en_init,
    output logic             phase_start,
    output logic [4:0]       cand_x,
    output logic [4:0]       cand_y,
    output logic             busy,
    output logic             done,
    output logic [4:0]       mv_x,
    output logic [4:0]       mv_y,
    output logic [SAD_W-1:0] min_sad
);

    localparam int N_RES  = N_POS * N_POS;
    localparam int INIT_W = $clog2(INIT_CYC + 1);
    localparam int PH_W   = $clog2(PHASE_LEN + 1);
    localparam int RES_W  = $clog2(N_RES + 1);

    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYC - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(PHASE_LEN - 1);
    localparam logic [RES_W-1:0]  RES_LAST  = RES_W'(N_RES - 1);
    localparam logic [RES_W-1:0]  RES_FULL  = RES_W'(N_RES);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(N_POS - 1);

    state_e           state_q, state_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic [PH_W-1:0]  phase_cnt_q, phase_cnt_d;
    logic [POS_W-1:0] cand_x_q, cand_x_d;
    logic [POS_W-1:0] cand_y_q, cand_y_d;
    logic [RES_W-1:0] res_cnt_q, res_cnt_d;
    logic [POS_W-1:0] res_x_q, res_x_d;
    logic [POS_W-1:0] res_y_q, res_y_d;

    logic accept;
    logic first_res;
    logic finish;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        phase_cnt_d = phase_cnt_q;
        cand_x_d    = cand_x_q;
        cand_y_d    = cand_y_q;
        res_cnt_d   = res_cnt_q;
        res_x_d     = res_x_q;
        res_y_d     = res_y_q;
        finish      = 1'b0;

        // Abort suppresses acceptance so the tracked minimum holds.
        accept    = sad_valid && !abort && (res_cnt_q != RES_FULL) &&
                    ((state_q == ST_RUN) || (state_q == ST_DRAIN));
        first_res = (res_cnt_q == '0);

        // Result counter walks the same raster order as candidate issue.
        if (accept) begin
            res_cnt_d = res_cnt_q + 1'b1;
            if (res_x_q == POS_LAST) begin
                res_x_d = '0;
                res_y_d = res_y_q + 1'b1;
            end else begin
                res_x_d = res_x_q + 1'b1;
            end
            if (res_cnt_q == RES_LAST) begin
                finish = 1'b1;
            end
`ifdef SEARCH_SCHED_EARLY_TERM_EN
            if (sad == '0) begin
                finish = 1'b1;
            end
`endif
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_INIT;
                    init_cnt_d  = '0;
                    phase_cnt_d = '0;
                    cand_x_d    = '0;
                    cand_y_d    = '0;
                    res_cnt_d   = '0;
                    res_x_d     = '0;
                    res_y_d     = '0;
                end
            end
            ST_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d     = ST_RUN;
                    phase_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (phase_cnt_q == PH_LAST) begin
                    phase_cnt_d = '0;
                    if (cand_x_q == POS_LAST) begin
                        if (cand_y_q == POS_LAST) begin
                            state_d = ST_DRAIN;
                        end else begin
                            cand_x_d = '0;
                            cand_y_d = cand_y_q + 1'b1;
                        end
                    end else begin
                        cand_x_d = cand_x_q + 1'b1;
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Completion overrides the phase-end transition; abort overrides both.
        if (finish) begin
            state_d = ST_DONE;
        end
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            init_cnt_q  <= '0;
            phase_cnt_q <= '0;
            cand_x_q    <= '0;
            cand_y_q    <= '0;
            res_cnt_q   <= '0;
            res_x_q     <= '0;
            res_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            phase_cnt_q <= phase_cnt_d;
            cand_x_q    <= cand_x_d;
            cand_y_q    <= cand_y_d;
            res_cnt_q   <= res_cnt_d;
            res_x_q     <= res_x_d;
            res_y_q     <= res_y_d;
        end
    end

    sad_min_track #(
        .SAD_W(SAD_W)
    ) u_min (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .first  (first_res),
        .sad    (sad),
        .x      (res_x_q),
        .y      (res_y_q),
        .mv_x   (mv_x),
        .mv_y   (mv_y),
        .min_sad(min_sad)
    );

    assign en_init     = (state_q == ST_INIT);
    assign phase_start = (state_q == ST_RUN) && (phase_cnt_q == '0);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign cand_x      = cand_x_q;
    assign cand_y      = cand_y_q;

endmodule

// File: tb/tb_search_sched.sv
// tb_search_sched: scoreboard bench for search_sched (N_POS=4).
// Expected candidate order and final results are queued at launch and
// popped when the DUT issues phase_start / done. A small PE model returns
// a SAD a fixed latency after each phase_start.
// Honours SEARCH_SCHED_EARLY_TERM_EN in its reference model.
module tb_search_sched;

    localparam int SAD_W     = 16;
    localparam int N_POS     = 4;
    localparam int PHASE_LEN = 24;
    localparam int INIT_CYC  = 73;
    localparam int N_RES     = N_POS * N_POS;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             sad_valid;
    logic [SAD_W-1:0] sad;
    logic             en_init;
    logic             phase_start;
    logic [4:0]       cand_x, cand_y;
    logic             busy;
    logic             done;
    logic [4:0]       mv_x, mv_y;
    logic [SAD_W-1:0] min_sad;

    search_sched #(
        .SAD_W    (SAD_W),
        .N_POS    (N_POS),
        .PHASE_LEN(PHASE_LEN),
        .INIT_CYC (INIT_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .sad_valid  (sad_valid),
        .sad        (sad),
        .en_init    (en_init),
        .phase_start(phase_start),
        .cand_x     (cand_x),
        .cand_y     (cand_y),
        .busy       (busy),
        .done       (done),
        .mv_x       (mv_x),
        .mv_y       (mv_y),
        .min_sad    (min_sad)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    typedef struct {
        int mx;
        int my;
        int ms;
        int nres;
    } res_t;

    res_t exp_res_q[$];
    int   exp_cand_q[$];
    int   pend_q[$];
    int   sad_tab[N_RES];
    int   pe_lat   = 5;
    bit   pe_en    = 1'b0;
    int   res_idx  = 0;
    int   cyc      = 0;
    int   zero_cyc = -100;
    int   init_len = 0;
    bit   en_prev  = 1'b0;
    bit   done_prev = 1'b0;
    int   last_ps  = -1;
    int   done_cnt = 0;

    // Monitor + PE model, all on the falling edge.
    initial begin
        sad_valid = 1'b0;
        sad       = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                sad_valid = 1'b0;
                en_prev   = 1'b0;
                done_prev = 1'b0;
                init_len  = 0;
                continue;
            end
            if (en_init) begin
                init_len++;
            end else if (en_prev) begin
                chk("init_len", init_len, INIT_CYC);
                chk("first_ps_after_init", phase_start, 1);
                init_len = 0;
                last_ps  = -1;
            end
            en_prev = en_init;

            if (done) begin
                done_cnt++;
                chk("done_pulse", done_prev, 0);
                if (exp_res_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    res_t r;
                    r = exp_res_q.pop_front();
                    chk("mv_x", mv_x, r.mx);
                    chk("mv_y", mv_y, r.my);
                    chk("min_sad", min_sad, r.ms);
                    chk("results_at_done", res_idx, r.nres);
`ifdef SEARCH_SCHED_EARLY_TERM_EN
                    if (r.nres < N_RES) chk("early_done_lat", cyc - zero_cyc, 1);
`endif
                end
            end
            done_prev = done;

            if (phase_start) begin
                if (last_ps >= 0) chk("phase_spacing", cyc - last_ps, PHASE_LEN);
                last_ps = cyc;
                if (exp_cand_q.size() == 0) begin
                    chk("unexpected_phase", 1, 0);
                end else begin
                    int e;
                    e = exp_cand_q.pop_front();
                    chk("cand", cand_y * 32 + cand_x, e);
                end
                if (pe_en) pend_q.push_back(cyc + pe_lat);
            end

            sad_valid = 1'b0;
            if (pend_q.size() > 0 && pend_q[0] == cyc && res_idx < N_RES) begin
                void'(pend_q.pop_front());
                sad_valid = 1'b1;
                sad       = SAD_W'(sad_tab[res_idx]);
                if (sad_tab[res_idx] == 0) zero_cyc = cyc;
                res_idx++;
            end
        end
    end

    // Build SAD table base - step*i (entry zero_at forced to 0), queue expectations, pulse start.
    task automatic launch(input int lat, input int base, input int step, input int zero_at);
        res_t r;
        r.mx = 0; r.my = 0; r.ms = 0; r.nres = N_RES;
        for (int i = 0; i < N_RES; i++) begin
            sad_tab[i] = (i == zero_at) ? 0 : base - step * i;
        end
        for (int i = 0; i < N_RES; i++) begin
            if (i == 0 || sad_tab[i] < r.ms) begin
                r.ms = sad_tab[i];
                r.mx = i % N_POS;
                r.my = i / N_POS;
            end
`ifdef SEARCH_SCHED_EARLY_TERM_EN
            if (sad_tab[i] == 0) begin
                r.nres = i + 1;
                break;
            end
`endif
        end
        exp_cand_q.delete();
        for (int y = 0; y < N_POS; y++)
            for (int x = 0; x < N_POS; x++)
                exp_cand_q.push_back(y * 32 + x);
        exp_res_q.push_back(r);
        pend_q.delete();
        res_idx  = 0;
        zero_cyc = -100;
        pe_lat   = lat;
        pe_en    = 1'b1;
        start    = 1'b1;
        @(posedge clk); #2;
        start    = 1'b0;
    endtask

    task automatic flush();
        pe_en = 1'b0;
        exp_cand_q.delete();
        exp_res_q.delete();
        pend_q.delete();
    endtask

    task automatic wait_done(input string tag);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < 1500) begin
            @(posedge clk); #2;
            n++;
        end
        chk({tag, "_done_seen"}, done_cnt - d0, 1);
        repeat (3) @(posedge clk);
        #2;
        chk({tag, "_idle_after"}, busy, 0);
        chk({tag, "_done_once"}, done_cnt - d0, 1);
        flush();
    endtask

    task automatic wait_cand(input int x, input int y);
        int n;
        n = 0;
        while (!(phase_start && cand_x == 5'(x) && cand_y == 5'(y)) && n < 1500) begin
            @(posedge clk); #2;
            n++;
        end
        chk("wait_cand_reached", (n < 1500) ? 1 : 0, 1);
    endtask

    initial begin
        int mx0, my0, ms0, d0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_en_init", en_init, 0);
        chk("rst_phase_start", phase_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cand", cand_y * 32 + cand_x, 0);
        chk("rst_mv", mv_y * 32 + mv_x, 0);
        chk("rst_min_sad", min_sad, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Decreasing SADs; last result lands on the final phase-end cycle.
        launch(23, 100, 1, -1);
        wait_cand(1, 0);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        chk("start_ignored_en_init", en_init, 0);
        chk("start_ignored_busy", busy, 1);
        wait_done("sweep");

        // All equal: tie keeps first candidate.
        launch(5, 50, 0, -1);
        wait_done("ties");

        // Abort at (2,1).
        launch(5, 90, 2, -1);
        wait_cand(2, 1);
        mx0 = mv_x; my0 = mv_y; ms0 = min_sad; d0 = done_cnt;
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        flush();
        repeat (40) @(posedge clk);
        #2;
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_mv_hold", mv_y * 32 + mv_x, my0 * 32 + mx0);
        chk("abort_min_hold", min_sad, ms0);
        launch(10, 300, 3, -1);
        wait_done("after_abort");

        // Zero SAD at result index 5 (candidate (1,1)).
        launch(5, 200, 1, 5);
        wait_done("zero");
        chk("zero_mv", mv_y * 32 + mv_x, 1 * 32 + 1);
        chk("zero_min", min_sad, 0);

        // Reset while draining.
        launch(30, 60, 1, -1);
        wait_cand(3, 3);
        repeat (26) @(posedge clk);
        #2;
        chk("drain_busy", busy, 1);
        chk("drain_cand_hold", cand_y * 32 + cand_x, 3 * 32 + 3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_cand", cand_y * 32 + cand_x, 0);
        chk("arst_mv", mv_y * 32 + mv_x, 0);
        chk("arst_min_sad", min_sad, 0);
        chk("arst_flags", {en_init, phase_start, done}, 0);
        flush();
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        launch(7, 40, 1, -1);
        wait_done("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/search_sched.md
SEARCH_SCHED -- requirements
Module: search_sched

Interface
REQ-001 SHALL have parameter SAD_W, default 16, meaning SAD result width.
REQ-002 SHALL have parameter N_POS, default 16, meaning candidate positions per axis (N_POS x N_POS grid, 2..32).
REQ-003 SHALL have parameter PHASE_LEN, default 24, meaning cycles per candidate phase.
REQ-004 SHALL have parameter INIT_CYC, default 73, meaning cycles en_init is held.
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  in  1  begin a block search (sampled in IDLE only).
REQ-008 SHALL have port abort  in  1  cancel the search in progress.
REQ-009 SHALL have port sad_valid  in  1  PE array SAD result strobe.
REQ-010 SHALL have port sad  in  SAD_W  SAD of the oldest outstanding candidate.
REQ-011 SHALL have port en_init  out  1  memory-initialisation enable to the phase controller.
REQ-012 SHALL have port phase_start  out  1  one-cycle pulse opening a candidate phase.
REQ-013 SHALL have port cand_x, cand_y  out  5 each  candidate issued in the current phase.
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.
REQ-015 SHALL have port done  out  1  one-cycle search-complete pulse.
REQ-016 SHALL have port mv_x, mv_y  out  5 each  best candidate; min_sad  out  SAD_W  its SAD.

Function
REQ-017 SHALL implement states IDLE, INIT, RUN, DRAIN, DONE.
REQ-018 IDLE->INIT SHALL occur on the cycle after start=1 is sampled; start in any other state SHALL be ignored.
REQ-019 en_init SHALL be high for exactly INIT_CYC consecutive cycles, all in INIT; then INIT->RUN.
REQ-020 In RUN a phase counter SHALL count 0..PHASE_LEN-1 and wrap; phase_start SHALL be 1 only when the count is 0.
REQ-021 Candidates SHALL issue raster order: cand_x increments at phase end, wraps N_POS-1->0 with cand_y+1.
REQ-022 After the phase of (N_POS-1, N_POS-1) ends, RUN->DRAIN; cand_x/cand_y SHALL hold the last value.
REQ-023 sad_valid SHALL be accepted only in RUN or DRAIN; each accepted result SHALL map to the next candidate in issue order via a result counter.
REQ-024 The first accepted result SHALL load min_sad/mv unconditionally; later results SHALL replace them only if sad < min_sad (strictly less; ties keep the earlier candidate).
REQ-025 When the result count reaches N_POS*N_POS, the state SHALL go to DONE next cycle; done=1 for that one cycle, then IDLE.
REQ-026 A result arriving in the same cycle as the last phase end SHALL be accepted and counted.
REQ-027 abort=1 in any non-IDLE state SHALL go to IDLE next cycle with no done pulse; mv/min_sad SHALL hold; abort in IDLE SHALL be ignored.
REQ-028 abort and the final sad_valid in the same cycle: abort SHALL win.
REQ-029 sad_valid beyond N_POS*N_POS results SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL force IDLE and zero all counters and outputs (en_init, phase_start, cand_x/y, busy, done, mv_x/y, min_sad) asynchronously, including mid-search.

Configuration
REQ-031 With macro SEARCH_SCHED_EARLY_TERM_EN defined, an accepted result with sad=0 SHALL update mv/min_sad and go to DONE next cycle regardless of count.
REQ-032 Without SEARCH_SCHED_EARLY_TERM_EN, every search SHALL complete all N_POS*N_POS results.

Structure
REQ-033 State enum, PHASE_LEN and INIT_CYC defaults SHALL live in shared package fsbm_pkg.
REQ-034 The compare/minimum register SHALL be sub-module sad_min_track (inputs: load, first, sad, x, y).

Verification (bench N_POS=4, PHASE_LEN=24, INIT_CYC=73)
REQ-035 start pulse -> en_init high 73 cycles, first phase_start on the next cycle, cand (0,0),(1,0)..(3,3) at 24-cycle spacing.
REQ-036 SADs 100 down to 85 in issue order -> done once, mv=(3,3), min_sad=85.
REQ-037 All SADs 50 -> mv=(0,0), min_sad=50 (tie rule).
REQ-038 abort in RUN at candidate (2,1) -> IDLE next cycle, busy=0, no done, mv unchanged; a subsequent start runs a full search normally.
REQ-039 With SEARCH_SCHED_EARLY_TERM_EN, sad=0 at result 5 -> done one cycle later, mv=(1,1), min_sad=0; without the macro, done only after 16 results.
REQ-040 rst_n low mid-DRAIN -> all outputs 0 immediately; start while busy -> no effect.
